// File: rtl/echo_pkg.sv
// Shared constants for the memory-access stage: datapath width, funct3
// load/store encodings, FSM states and the alignment rule.
package echo_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // funct3[1:0] encodes the access size for loads and stores alike.
    function automatic logic addr_ok(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b00:   addr_ok = 1'b1;
            2'b01:   addr_ok = ~lo[0];
            default: addr_ok = (lo == 2'b00);
        endcase
    endfunction
endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a load word and sign- or
// zero-extends it according to funct3.
module load_extend #(
    parameter int XLEN = echo_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);
    import echo_pkg::*;

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{lo, 3'b000} +: 8];
    assign h = rdata[{lo[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3)
            F3_B:    data = {{(XLEN-8){b[7]}}, b};
            F3_BU:   data = {{(XLEN-8){1'b0}}, b};
            F3_H:    data = {{(XLEN-16){h[15]}}, h};
            F3_HU:   data = {{(XLEN-16){1'b0}}, h};
            F3_W:    data = rdata;
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/memaccess.sv
// Pipeline memory stage: passes ALU results through, issues one aligned
// load/store at a time on a req/ack bus and stalls upstream until it completes.
module memaccess #(
    parameter int XLEN = echo_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] res,
    input  logic [XLEN-1:0] store_val,
    input  logic [2:0]      funct3,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [XLEN-1:0] pcp4,
    input  logic            use_pcp4,
    output logic            stall,
    output logic            en_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] res_out,
    output logic [XLEN-1:0] pcp4_out,
    output logic            use_pcp4_out,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            misaligned
);
    import echo_pkg::*;

    state_t          state, state_nx;
    logic            access, aligned, start;
    logic [3:0]      wstrb_nx;
    logic [XLEN-1:0] wdata_nx, ld_data;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic [XLEN-1:0] pcp4_q;
    logic            use_q, ld_q;

    assign access  = is_load | is_store;
    assign aligned = addr_ok(funct3, res[1:0]);
    assign start   = (state == IDLE) && en && access && aligned;
    assign stall   = !rst && (start || (state == WAIT && !mem_ack));

    always_comb begin
        wstrb_nx = 4'b1111;
        wdata_nx = store_val;
        case (funct3[1:0])
            2'b00: begin
                wstrb_nx = 4'b0001 << res[1:0];
                wdata_nx = {(XLEN/8){store_val[7:0]}};
            end
            2'b01: begin
                wstrb_nx = 4'b0011 << res[1:0];
                wdata_nx = {(XLEN/16){store_val[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = WAIT;
            WAIT:    if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    load_extend #(.XLEN(XLEN)) u_ext (
        .funct3 (f3_q),
        .lo     (lo_q),
        .rdata  (mem_rdata),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out       <= 1'b0;
            rd_out       <= '0;
            res_out      <= '0;
            pcp4_out     <= '0;
            use_pcp4_out <= 1'b0;
            misaligned   <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            rd_q         <= '0;
            f3_q         <= '0;
            lo_q         <= '0;
            pcp4_q       <= '0;
            use_q        <= 1'b0;
            ld_q         <= 1'b0;
        end else begin
            en_out     <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    if (!access || !aligned) begin
                        en_out       <= 1'b1;
                        misaligned   <= access;
                        rd_out       <= access ? 5'd0 : rd;
                        res_out      <= res;
                        pcp4_out     <= pcp4;
                        use_pcp4_out <= use_pcp4;
                    end else begin
                        // A simultaneous load+store flag is executed as a load.
                        mem_req   <= 1'b1;
                        mem_we    <= is_store & ~is_load;
                        mem_addr  <= {res[XLEN-1:2], 2'b00};
                        mem_wdata <= wdata_nx;
                        mem_wstrb <= wstrb_nx;
                        rd_q      <= is_load ? rd : 5'd0;
                        f3_q      <= funct3;
                        lo_q      <= res[1:0];
                        pcp4_q    <= pcp4;
                        use_q     <= use_pcp4;
                        ld_q      <= is_load;
                    end
                end
                WAIT: if (mem_ack) begin
                    mem_req      <= 1'b0;
                    en_out       <= 1'b1;
                    rd_out       <= rd_q;
                    res_out      <= ld_q ? ld_data : {mem_addr[XLEN-1:2], lo_q};
                    pcp4_out     <= pcp4_q;
                    use_pcp4_out <= use_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memaccess.sv
// Randomized bench for memaccess: a queue of predicted completions and
// expected bus activity is checked every cycle, plus directed literal cases.
module tb_memaccess;
    logic        clk = 1'b0;
    logic        rst, en, is_load, is_store, use_pcp4, mem_ack;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] res, store_val, pcp4, mem_rdata;
    logic        stall, en_out, use_pcp4_out, mem_req, mem_we, misaligned;
    logic [4:0]  rd_out;
    logic [31:0] res_out, pcp4_out, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    memaccess dut (
        .clk(clk), .rst(rst), .en(en), .rd(rd), .res(res), .store_val(store_val),
        .funct3(funct3), .is_load(is_load), .is_store(is_store), .pcp4(pcp4),
        .use_pcp4(use_pcp4), .stall(stall), .en_out(en_out), .rd_out(rd_out),
        .res_out(res_out), .pcp4_out(pcp4_out), .use_pcp4_out(use_pcp4_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] pc;
        logic        up;
        logic        mis;
        bit          chk_res;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0, stall_cnt = 0;
    bit          chk_en = 0;
    logic        exp_stall = 0, exp_req = 0, exp_we = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0;
    logic [3:0]  exp_wstrb = 0;
    logic [31:0] seen_addr = 0, seen_wdata = 0;
    logic [3:0]  seen_wstrb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rules expressed as byte arithmetic.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_ok(input logic [2:0] f3, input logic [31:0] a);
        return (a % nbytes(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        longint v;
        int     n;
        n = nbytes(f3);
        v = longint'(rdata >> (8 * (a % 4))) & ((64'sd1 << (8 * n)) - 1);
        if (!f3[2] && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << nbytes(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sv);
        if (nbytes(f3) == 1) return sv[7:0] * 32'h01010101;
        if (nbytes(f3) == 2) return sv[15:0] * 32'h00010001;
        return sv;
    endfunction

    // Per-cycle compare process, sampling mid-cycle after the driver has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                chk("stall", stall, exp_stall);
                chk("mem_req", mem_req, exp_req);
                if (mem_req) begin
                    seen_addr  = mem_addr;
                    seen_wdata = mem_wdata;
                    seen_wstrb = mem_wstrb;
                end
                if (exp_req) begin
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_we", mem_we, exp_we);
                    if (exp_we) begin
                        chk("mem_wdata", mem_wdata, exp_wdata);
                        chk("mem_wstrb", mem_wstrb, exp_wstrb);
                    end
                end
                if (q.size() > 0 && q[0].due < cyc) begin
                    chk("lost_completion", 32'(q[0].due), 32'(cyc));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("en_out", en_out, 1);
                    chk("rd_out", rd_out, e.rd);
                    chk("misaligned", misaligned, e.mis);
                    chk("pcp4_out", pcp4_out, e.pc);
                    chk("use_pcp4_out", use_pcp4_out, e.up);
                    if (e.chk_res) chk("res_out", res_out, e.res);
                end else begin
                    chk("en_out_idle", en_out, 0);
                    chk("misaligned_idle", misaligned, 0);
                end
                if (stall) stall_cnt++;
            end
        end
    end

    task automatic idle(input int n);
        en = 0; is_load = 0; is_store = 0; exp_stall = 0;
        repeat (n) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
        end
        mem_ack = 0;
    endtask

    // Issues one op at a negedge; returns at the negedge where its completion is visible.
    task automatic op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sv, input logic [4:0] r, input int d,
                      input logic [31:0] rdata);
        exp_t e;
        en = 1; is_load = ld; is_store = st; funct3 = f3; res = a; store_val = sv; rd = r;
        pcp4 = $urandom; use_pcp4 = 1'($urandom_range(0, 1)); mem_ack = 0;
        e.pc = pcp4; e.up = use_pcp4; e.mis = 0; e.res = a; e.rd = r; e.chk_res = 1;
        if (!(ld || st) || !m_ok(f3, a)) begin
            if (ld || st) begin e.mis = 1; e.rd = 0; e.chk_res = 0; end
            e.due = cyc + 1;
            q.push_back(e);
            exp_stall = 0;
            @(negedge clk);
        end else begin
            e.due = cyc + 2 + d;
            e.rd = ld ? r : 5'd0;
            e.res = m_load(f3, a, rdata);
            e.chk_res = ld;
            q.push_back(e);
            exp_stall = 1;
            @(negedge clk);
            exp_req = 1; exp_we = st && !ld; exp_addr = a - (a % 4);
            exp_wdata = m_wdata(f3, sv); exp_wstrb = m_strb(f3, a);
            repeat (d) @(negedge clk);
            mem_ack = 1; mem_rdata = rdata; exp_stall = 0;
            @(negedge clk);
            mem_ack = 0; exp_req = 0; mem_rdata = $urandom;
        end
        en = 0; is_load = 0; is_store = 0;
    endtask

    logic [2:0]  lf[5];
    logic [2:0]  f3r;
    logic [31:0] ar;
    int          kind;
    bit          ldr, str;

    initial begin
        lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;
        rst = 1; en = 0; is_load = 0; is_store = 0; use_pcp4 = 0; mem_ack = 0;
        rd = 0; funct3 = 0; res = 0; store_val = 0; pcp4 = 0; mem_rdata = 0;
        #1;
        chk("rst_en_out", en_out, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_res_out", res_out, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_bus", mem_addr | mem_wdata | mem_wstrb | mem_we, 0);
        chk("rst_misc", stall | misaligned | use_pcp4_out | pcp4_out, 0);
        repeat (2) @(negedge clk);
        rst = 0; chk_en = 1;

        op(0, 0, 3'b000, 32'h1234, 0, 5'd5, 0, 0);
        #3 chk("alu_res", res_out, 32'h1234); chk("alu_rd", rd_out, 5);
        chk("alu_en", en_out, 1); chk("alu_req", mem_req, 0);
        @(negedge clk);

        stall_cnt = 0;
        op(1, 0, 3'b000, 32'h103, 0, 5'd9, 3, 32'h80000000);
        #3 chk("lb_res", res_out, 32'hFFFFFF80); chk("lb_stall_cycles", stall_cnt, 4);
        chk("lb_addr", seen_addr, 32'h100);
        @(negedge clk);

        op(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 5'd7, 1, 0);
        #3 chk("sh_wstrb", seen_wstrb, 4'b1100); chk("sh_wdata", seen_wdata, 32'hABCDABCD);
        chk("sh_en", en_out, 1); chk("sh_rd", rd_out, 0);
        @(negedge clk);

        op(1, 0, 3'b010, 32'h101, 0, 5'd3, 0, 0);
        #3 chk("lw_mis", misaligned, 1); chk("lw_mis_en", en_out, 1);
        chk("lw_mis_rd", rd_out, 0); chk("lw_mis_req", mem_req, 0);
        @(negedge clk);
        #3 chk("lw_mis_oneshot", misaligned, 0);
        @(negedge clk);

        op(1, 0, 3'b101, 32'h102, 0, 5'd4, 0, 32'h8001FFFF);
        #3 chk("lhu_res", res_out, 32'h00008001);
        @(negedge clk);

        op(1, 1, 3'b010, 32'h40, 32'hDEAD, 5'd6, 1, 32'h11223344);
        #3 chk("ldst_res", res_out, 32'h11223344); chk("ldst_rd", rd_out, 6);
        @(negedge clk);

        op(1, 0, 3'b000, 32'h41, 0, 5'd0, 2, 32'h0000AB00);
        #3 chk("lb_rd0_rd", rd_out, 0); chk("lb_rd0_res", res_out, 32'hFFFFFFAB);
        @(negedge clk);

        // Reset in the middle of a pending access, followed by a late ack.
        chk_en = 0; q.delete();
        en = 1; is_load = 1; is_store = 0; funct3 = 3'b010; res = 32'h200; rd = 5'd8;
        @(negedge clk);
        #1 chk("rst_wait_req_before", mem_req, 1);
        rst = 1;
        #1 chk("rst_wait_req_async", mem_req, 0);
        chk("rst_wait_en", en_out, 0); chk("rst_wait_stall", stall, 0);
        en = 0; is_load = 0;
        @(negedge clk); rst = 0;
        @(negedge clk); mem_ack = 1;
        @(negedge clk); mem_ack = 0;
        #1 chk("stray_ack_en", en_out, 0); chk("stray_ack_req", mem_req, 0);
        exp_stall = 0; exp_req = 0; chk_en = 1;
        @(negedge clk);
        op(0, 0, 3'b011, 32'hCAFE0001, 0, 5'd12, 0, 0);
        #3 chk("post_rst_alu", res_out, 32'hCAFE0001);
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            ar = $urandom;
            ldr = (kind == 1) || (kind == 2 && $urandom_range(0, 9) == 0);
            str = (kind == 2);
            if (kind == 1) f3r = lf[$urandom_range(0, 4)];
            else if (kind == 2) f3r = 3'($urandom_range(0, 2));
            else f3r = 3'($urandom_range(0, 7));
            op(ldr, str, f3r, ar, $urandom, 5'($urandom_range(0, 31)),
               $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
